pipelined_addsub: RTL and testbench
===================================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; WIDTH % STAGES == 0; chunk width CW = WIDTH/STAGES.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) or borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result fields valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  final carry; for sub, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Add: {cout,sum} = a + b + cin; sub: {cout,sum} = a + ~b + !cin, i.e. a - b - cin; widths modulo 2^WIDTH.
REQ-018 ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the inverted b under sub.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k of a and B' with the carry registered out of stage k-1 (stage 0 uses effective carry-in), and register chunk-k sum and carry-out.
REQ-020 Unprocessed upper operand chunks SHALL be carried forward in stage registers; completed lower sum chunks SHALL be carried forward alongside.
REQ-021 Each stage SHALL hold a valid bit; stage k loads when its valid is 0 or stage k+1 loads; the last stage loads when out_valid is 0 or out_ready is 1.
REQ-022 in_ready SHALL equal the stage-0 load condition; an operation is accepted when in_valid && in_ready.
REQ-023 Latency with out_ready held high SHALL be exactly STAGES cycles from acceptance to out_valid; throughput one operation per cycle.
REQ-024 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-025 sum, cout, ovf, zero SHALL be stable while out_valid && !out_ready.
REQ-026 With all stages full and out_ready low, in_ready SHALL be 0; the block holds exactly STAGES operations.
REQ-027 Simultaneous output handshake and input acceptance with a full pipeline SHALL advance every stage by one in that cycle.
REQ-028 Bubbles SHALL collapse: an empty stage loads from its predecessor even while later stages stall.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0; in_ready = 1 afterwards.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no stale result appears after release.

Structure
REQ-031 A shared package SHALL hold the WIDTH/STAGES defaults and the mode encoding constants ADD = 0, SUB = 1.
REQ-032 One sub-module, addsub_chunk (CW-bit combinational ripple adder with carry in/out), SHALL be instantiated once per stage.

Verification (WIDTH=16, STAGES=4)
REQ-033 Add 0xFFFF + 0x0001, cin=0, out_ready=1 -> after 4 cycles sum=0x0000, cout=1, zero=1, ovf=0.
REQ-034 Add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0; sub 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-035 Sub 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x1234 - 0x1233, cin=1 -> sum=0x0000, zero=1, cout=1.
REQ-036 Backpressure: in_valid high with 8 distinct ops, out_ready=0 -> in_ready falls after 4 accepts, out_valid high with first result held stable; raising out_ready drains all 8 in order, one per cycle.
REQ-037 Random out_ready and in_valid over 10k ops vs. a reference model -> all results match and arrive in order.
REQ-038 Assert rst_n with 3 ops in flight -> out_valid=0 immediately; after release no result emerges until a new op is accepted.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   ADDSUB_WIDTH / ADDSUB_STAGES : default operand width and pipeline depth
//   ADD / SUB                    : encoding of the 'sub' mode input
package pipelined_addsub_pkg;

    localparam int ADDSUB_WIDTH  = 16;
    localparam int ADDSUB_STAGES = 4;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// addsub_chunk: CW-bit combinational ripple adder, one per pipeline stage.
//   a, b : chunk operands (b already inverted by the caller for subtract)
//   ci   : carry into the chunk
//   s    : chunk sum
//   co   : carry out of the chunk
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    logic [CW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CW];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained
// chunks, one chunk per stage, with valid/ready flow control at both ends.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (sum, cout, ovf, zero)
// Stage k adds chunk k using the carry registered by stage k-1. Operands
// travel with the operation so later stages still see their chunks, and the
// partial sum grows by one chunk per stage. WIDTH must be a multiple of STAGES.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = ADDSUB_WIDTH,
    parameter int STAGES = ADDSUB_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // Subtract is a + ~b + !cin, so both b and the carry-in are inverted.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = (sub == SUB) ? ~b : b;
    assign c_eff = (sub == SUB) ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             vld_q, ld, src_vld, src_c, co, c_q;
        logic [WIDTH-1:0] src_a, src_b, src_s, nxt_s, a_q, b_q, s_q;
        logic [CW-1:0]    cs;
        logic             unused_lo;

        if (k == 0) begin : g_head
            assign src_vld = in_valid;
            assign src_a   = a;
            assign src_b   = b_eff;
            assign src_s   = '0;
            assign src_c   = c_eff;
        end else begin : g_body
            assign src_vld = g_stg[k-1].vld_q;
            assign src_a   = g_stg[k-1].a_q;
            assign src_b   = g_stg[k-1].b_q;
            assign src_s   = g_stg[k-1].s_q;
            assign src_c   = g_stg[k-1].c_q;
        end

        // A stage may load when it is empty or its content moves on this
        // cycle; this lets bubbles collapse while downstream is stalled.
        if (k == L) begin : g_tail
            assign ld = !vld_q || out_ready;
        end else begin : g_mid
            assign ld = !vld_q || g_stg[k+1].ld;
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .a  (src_a[k*CW +: CW]),
            .b  (src_b[k*CW +: CW]),
            .ci (src_c),
            .s  (cs),
            .co (co)
        );

        always_comb begin
            nxt_s              = src_s;
            nxt_s[k*CW +: CW]  = cs;
        end

        // Already-consumed operand chunks and the not-yet-computed sum chunk
        // are dead at this stage.
        assign unused_lo = ^{src_a, src_b, src_s};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
            end else if (ld) begin
                vld_q <= src_vld;
                a_q   <= src_a;
                b_q   <= src_b;
                s_q   <= nxt_s;
                c_q   <= co;
            end
        end
    end

    assign in_ready  = g_stg[0].ld;
    assign out_valid = g_stg[L].vld_q;
    assign sum       = g_stg[L].s_q;
    assign cout      = g_stg[L].c_q;

    // Signed overflow: operands (b already inverted for subtract) agree in
    // sign but the result does not.
    assign ovf  = (g_stg[L].a_q[WIDTH-1] == g_stg[L].b_q[WIDTH-1]) &&
                  (g_stg[L].s_q[WIDTH-1] != g_stg[L].a_q[WIDTH-1]);
    // Qualified by out_valid so an idle/reset pipeline reports zero = 0.
    assign zero = out_valid && (g_stg[L].s_q == '0);

    logic unused_out;
    assign unused_out = ^{g_stg[L].a_q[WIDTH-2:0], g_stg[L].b_q[WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         cin = 1'b0, sub = ADD;
    logic         out_valid, out_ready = 1'b1;
    logic         cout, ovf, zero;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t exp_next;
    int   tests = 0, fails = 0, cyc = 0, pops = 0;
    bit   lat_chk = 1'b0, bp_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s == SUB) begin
            r      = ux - uy - int'(c);
            sr     = sx - sy - int'(c);
            e.cout = (r >= 0);
        end else begin
            r      = ux + uy + int'(c);
            sr     = sx + sy + int'(c);
            e.cout = (r > 65535);
        end
        e.sum  = r[W-1:0];
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (e.sum == '0);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o,
                                input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.cyc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: push on input handshake, compare on output.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("result", {13'd0, sum, cout, ovf, zero},
                        {13'd0, q[0].sum, q[0].cout, q[0].ovf, q[0].zero});
                    if (lat_chk) chk("latency", cyc - q[0].cyc, S);
                    if (out_ready) begin
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e     = exp_next;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 after the op is accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input exp_t e);
        int n = 0;
        a = ta; b = tb_v; cin = tc; sub = ts; exp_next = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic send_rand();
        logic [W-1:0] x, y;
        logic c, s;
        x = rv(); y = rv(); c = 1'($urandom()); s = 1'($urandom());
        send(x, y, c, s, model(x, y, c, s));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [18:0]  held;
        logic [W-1:0] x, y;
        int           p0;
        bit           stray;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("reset_outputs", {12'd0, out_valid, sum, cout, ovf, zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed corner cases, back to back, out_ready high
        lat_chk = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, ADD, mk(16'h0000, 1, 0, 1));
        send(16'h7FFF, 16'h0001, 1'b0, ADD, mk(16'h8000, 0, 1, 0));
        send(16'h8000, 16'h0001, 1'b0, SUB, mk(16'h7FFF, 1, 1, 0));
        send(16'h0005, 16'h0007, 1'b0, SUB, mk(16'hFFFE, 0, 0, 0));
        send(16'h1234, 16'h1233, 1'b1, SUB, mk(16'h0000, 1, 0, 1));
        send(16'h00FF, 16'h0001, 1'b0, ADD, mk(16'h0100, 0, 0, 0));
        send(16'h1234, 16'h0000, 1'b1, ADD, mk(16'h1235, 0, 0, 0));
        send(16'h0000, 16'h8000, 1'b0, SUB, mk(16'h8000, 0, 1, 0));
        drain(50);
        lat_chk = 1'b0;

        // Backpressure: fill with 4, hold a 5th, then drain 8 in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 16'(16'h1111 * (i + 1)); y = 16'(16'h0101 * (i + 3));
            send(x, y, 1'b0, ADD, model(x, y, 1'b0, ADD));
        end
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        held = {sum, cout, ovf, zero};
        x = 16'hA5A5; y = 16'h5A5A;
        exp_next = model(x, y, 1'b1, SUB);
        a = x; b = y; cin = 1'b1; sub = SUB; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
        end
        chk("hold_stable", {13'd0, sum, cout, ovf, zero}, {13'd0, held});
        chk("hold_count", q.size(), 4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        p0 = pops;
        send(x, y, 1'b1, SUB, model(x, y, 1'b1, SUB));
        for (int i = 0; i < 3; i++) begin
            x = 16'(16'hF00F - i); y = 16'(16'h0F0F * (i + 1));
            send(x, y, 1'b0, SUB, model(x, y, 1'b0, SUB));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_rate", pops - p0, 8);
        drain(20);

        // Random traffic against the model with random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send_rand();
        end
        bp_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(2000);

        // Reset with operations in flight
        out_ready = 1'b0;
        repeat (3) send_rand();
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_async", {12'd0, out_valid, sum, cout, ovf, zero}, 32'd0);
        q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        chk("no_stale_after_reset", stray, 0);
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(16'h4321, 16'h1234, 1'b0, ADD, mk(16'h5555, 0, 0, 0));
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
